// File: rtl/config_pkg.sv
// Core-wide configuration record shared by the memory-side blocks.
// The store port reads only the physical address width and the datapath width.
package config_pkg;

    typedef struct packed {
        logic [31:0] PLEN;
        logic [31:0] XLEN;
    } cfg_t;

    localparam cfg_t DefaultCfg = '{PLEN: 32'd32, XLEN: 32'd32};

endpackage

// File: rtl/dcache_pkg.sv
// D-cache shared types: the LSU op encoding, store lane layout and store-port FSM states.
// store_lanes() is shared with the load path, so it is kept free of any port-specific state.
package dcache_pkg;

    typedef enum logic [3:0] {
        LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU,
        LSU_SB, LSU_SH, LSU_SW, LSU_NONE
    } lsu_op_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_lanes_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_LOOKUP, ST_MEM_REQ, ST_MEM_WAIT
    } store_state_e;

    // Right-aligned store data is replicated across the word, so the byte enables alone select lanes.
    function automatic store_lanes_t store_lanes(input lsu_op_e op, input logic [1:0] addr_lo,
                                                 input logic [31:0] data);
        store_lanes_t l;
        l = '0;
        case (op)
            LSU_SB: begin
                l.be    = 4'b0001 << addr_lo;
                l.wdata = {4{data[7:0]}};
            end
            LSU_SH: begin
                l.be    = 4'b0011 << {addr_lo[1], 1'b0};
                l.wdata = {2{data[15:0]}};
            end
            LSU_SW: begin
                l.be    = '1;
                l.wdata = data;
            end
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/dcache_store_port_lane_gen.sv
// Combinational byte-lane generator for stores: op + address offset to byte enables,
// replicated write data and a drop flag for misaligned or non-store ops.
module store_lane_gen
    import dcache_pkg::*;
(
    input  lsu_op_e      op,
    input  logic [1:0]   addr_lo,
    input  logic [31:0]  data,
    output store_lanes_t lanes,
    output logic         misaligned
);

    always_comb begin
        lanes      = store_lanes(op, addr_lo, data);
        misaligned = 1'b1;
        case (op)
            LSU_SB:  misaligned = 1'b0;
            LSU_SH:  misaligned = addr_lo[0];
            LSU_SW:  misaligned = |addr_lo;
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dcache_store_port.sv
// Write-through store responder: tag lookup, data-array update on hit, then one
// memory write per store. One store in flight; misaligned/illegal stores are dropped.
module dcache_store_port
    import dcache_pkg::*;
#(
    parameter int unsigned      SETS       = 64,
    parameter int unsigned      LINE_BYTES = 16,
    parameter config_pkg::cfg_t Cfg        = config_pkg::DefaultCfg,
    localparam int unsigned     PLEN       = Cfg.PLEN,
    localparam int unsigned     OFF        = $clog2(LINE_BYTES),
    localparam int unsigned     IDX        = $clog2(SETS),
    localparam int unsigned     TAGW       = PLEN - OFF - IDX
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dcache_req_valid_i,
    output logic            dcache_req_ready_o,
    input  logic [PLEN-1:0] dcache_req_addr_i,
    input  logic [31:0]     dcache_req_data_i,
    input  lsu_op_e         dcache_req_op_i,
    output logic            tag_rd_en_o,
    output logic [IDX-1:0]  tag_rd_idx_o,
    input  logic [TAGW-1:0] tag_rd_tag_i,
    input  logic            tag_rd_valid_i,
    output logic            data_we_o,
    output logic [IDX-1:0]  data_w_idx_o,
    output logic [OFF-3:0]  data_w_word_o,
    output logic [31:0]     data_w_wdata_o,
    output logic [3:0]      data_w_be_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [PLEN-1:0] mem_req_addr_o,
    output logic [31:0]     mem_req_wdata_o,
    output logic [3:0]      mem_req_wstrb_o,
    input  logic            mem_resp_valid_i,
    output logic            busy_o,
    output logic            misalign_o,
    output logic [31:0]     hit_cnt_o,
    output logic [31:0]     miss_cnt_o
);

    store_state_e   state;
    logic [PLEN-1:2] req_addr;
    logic [31:0]    req_wdata;
    logic [3:0]     req_be;
    logic           misalign_q;
    logic [31:0]    hit_cnt;
    logic [31:0]    miss_cnt;
    store_lanes_t   lanes;
    logic           misaligned;
    logic           accept;
    logic           hit;

    store_lane_gen u_lane_gen (
        .op         (dcache_req_op_i),
        .addr_lo    (dcache_req_addr_i[1:0]),
        .data       (dcache_req_data_i),
        .lanes      (lanes),
        .misaligned (misaligned)
    );

    assign accept = (state == ST_IDLE) && dcache_req_valid_i;
    assign hit    = tag_rd_valid_i && (tag_rd_tag_i == req_addr[PLEN-1:OFF+IDX]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_be     <= '0;
            misalign_q <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            req_addr  <= dcache_req_addr_i[PLEN-1:2];
                            req_wdata <= lanes.wdata;
                            req_be    <= lanes.be;
                            state     <= ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                    end
                    state <= ST_MEM_REQ;
                end
                ST_MEM_REQ: begin
                    if (mem_req_ready_i) state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (mem_resp_valid_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Index is gated so the tag port is quiet whenever no lookup is issued.
    assign dcache_req_ready_o = (state == ST_IDLE);
    assign tag_rd_en_o        = accept && !misaligned;
    assign tag_rd_idx_o       = tag_rd_en_o ? dcache_req_addr_i[OFF+IDX-1:OFF] : '0;

    assign data_we_o      = (state == ST_LOOKUP) && hit;
    assign data_w_idx_o   = req_addr[OFF+IDX-1:OFF];
    assign data_w_word_o  = req_addr[OFF-1:2];
    assign data_w_wdata_o = req_wdata;
    assign data_w_be_o    = req_be;

    assign mem_req_valid_o = (state == ST_MEM_REQ);
    assign mem_req_addr_o  = {req_addr, 2'b00};
    assign mem_req_wdata_o = req_wdata;
    assign mem_req_wstrb_o = req_be;

    assign busy_o     = (state != ST_IDLE);
    assign misalign_o = misalign_q;
    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;

endmodule
